// File: rtl/pwm_frame_scheduler.sv
// pwm_frame_scheduler: double-buffered duty bank serialised into the PWM loader.
// Optional wait-state watchdog: define PWM_SCHED_WDOG_EN.
module pwm_frame_scheduler #(
  parameter int STAGE       = 8,
  parameter int DWIDTH      = 8,
  parameter int BEAT_CYCLES = 32,
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [$clog2(STAGE)-1:0] cfg_addr,
  input  logic [DWIDTH-1:0]        cfg_wdata,
  input  logic                     commit,
  input  logic                     pwm_busy,
  output logic                     pwm_start,
  output logic [DWIDTH-1:0]        pwm_data,
  output logic                     pwm_data_vld,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  output logic                     commit_pending,
  output logic                     sched_err
);

  localparam int AW = $clog2(STAGE);
  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW-1:0] BEAT_LAST = AW'(STAGE - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // With no gap the frame end drops straight back to IDLE
  localparam state_t S_POST = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t            state_q;
  logic [AW-1:0]     beat_q;
  logic [CW-1:0]     cyc_q;
  logic [GW-1:0]     gap_q;
  logic [DWIDTH-1:0] shadow_q [STAGE];
  logic [DWIDTH-1:0] active_q [STAGE];
  logic              pend_q;
  logic              pend_d;
  logic              start_q;
  logic              vld_q;
  logic              done_q;
  logic [DWIDTH-1:0] data_q;
  logic [15:0]       cnt_q;
  logic              apply;
  logic              nonzero;

`ifdef PWM_SCHED_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wd_q;
  logic          err_q;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
`endif

  assign apply  = (state_q == S_IDLE) && enable && pend_q;
  assign pend_d = commit || (pend_q && !apply);

  always_comb begin
    nonzero = 1'b0;
    for (int i = 0; i < STAGE; i++) begin
      nonzero = nonzero | (|active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGE; i++) shadow_q[i] <= '0;
      pend_q <= 1'b0;
    end else begin
      if (cfg_we && (int'(cfg_addr) < STAGE)) begin
        shadow_q[cfg_addr] <= cfg_wdata;
      end
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < STAGE; i++) active_q[i] <= '0;
`ifdef PWM_SCHED_WDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_LOAD;
            beat_q  <= '0;
            cyc_q   <= '0;
            start_q <= 1'b1;
            vld_q   <= 1'b1;
            data_q  <= pend_q ? shadow_q[0] : active_q[0];
            if (pend_q) active_q <= shadow_q;
          end
        end
        S_LOAD: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q   <= '0;
            start_q <= 1'b0;
            if (beat_q == BEAT_LAST) begin
              vld_q  <= 1'b0;
              data_q <= '0;
              if (nonzero) begin
                state_q <= S_WAIT_ACT;
`ifdef PWM_SCHED_WDOG_EN
                wd_q    <= '0;
`endif
              end else begin
                done_q  <= 1'b1;
                cnt_q   <= cnt_q + 1'b1;
                gap_q   <= '0;
                state_q <= S_POST;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
              data_q <= active_q[beat_q + 1'b1];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_WAIT_ACT: begin
          if (pwm_busy) begin
            state_q <= S_WAIT_DONE;
`ifdef PWM_SCHED_WDOG_EN
            wd_q    <= '0;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            start_q <= 1'b0;
            vld_q   <= 1'b0;
            gap_q   <= '0;
            state_q <= S_POST;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (!pwm_busy) begin
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
            gap_q   <= '0;
            state_q <= S_POST;
`ifdef PWM_SCHED_WDOG_EN
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            start_q <= 1'b0;
            vld_q   <= 1'b0;
            gap_q   <= '0;
            state_q <= S_POST;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pwm_start      = start_q;
  assign pwm_data       = data_q;
  assign pwm_data_vld   = vld_q;
  assign frame_done     = done_q;
  assign frame_cnt      = cnt_q;
  assign commit_pending = pend_q;

`ifdef PWM_SCHED_WDOG_EN
  assign sched_err = err_q;
`else
  assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// tb_pwm_frame_scheduler: randomized frames against a bank/frame model.
// Default build only (watchdog disabled).
module tb_pwm_frame_scheduler;

  localparam int STAGE = 8;
  localparam int BEAT  = 32;
  localparam int GAP   = 4;
  localparam int FRAME = STAGE * BEAT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        commit;
  logic        pwm_busy;
  logic        pwm_start;
  logic [7:0]  pwm_data;
  logic        pwm_data_vld;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        commit_pending;
  logic        sched_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] m_shadow [STAGE];
  logic [7:0] m_active [STAGE];
  bit         m_pend;
  int         m_cnt;

  logic       tr_start [FRAME];
  logic       tr_vld   [FRAME];
  logic [7:0] tr_data  [FRAME];
  int lat, done_k, ndone, next_k, cp0, vld_after;

  pwm_frame_scheduler #(
    .STAGE(STAGE), .DWIDTH(8), .BEAT_CYCLES(BEAT),
    .GAP_CYCLES(GAP), .WDOG_CYCLES(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .commit(commit), .pwm_busy(pwm_busy),
    .pwm_start(pwm_start), .pwm_data(pwm_data),
    .pwm_data_vld(pwm_data_vld), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .commit_pending(commit_pending),
    .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_all_zero();
    for (int i = 0; i < STAGE; i++) if (m_active[i] != 8'h00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_start_frame();
    if (m_pend) begin
      m_active = m_shadow;
      m_pend = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < STAGE; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pend = 1'b0;
    m_cnt = 0;
  endfunction

  // Zero bank skips the wait states; otherwise done follows busy fall by one.
  function automatic int exp_done(input int rise, input int len);
    if (m_all_zero()) return FRAME;
    return rise + len + 1;
  endfunction

  // Beat data if the beat is a clean BEAT-cycle hold, else 9'h100.
  function automatic logic [8:0] beat_value(input int b);
    logic [7:0] d;
    int k;
    d = tr_data[b*BEAT];
    for (int i = 0; i < BEAT; i++) begin
      k = b * BEAT + i;
      if (tr_data[k] !== d || tr_vld[k] !== 1'b1 || tr_start[k] !== (b == 0))
        return 9'h100;
    end
    return {1'b0, d};
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input bit c);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    commit = c;
    step();
    cfg_we = 1'b0;
    commit = 1'b0;
    m_shadow[a] = d;
    if (c) m_pend = 1'b1;
  endtask

  task automatic cfg_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic run_frame(input int rise, input int len, input bit keep_en,
                           input int wk, input bit wwe, input logic [2:0] wa,
                           input logic [7:0] wd, input bit wc);
    int lim;
    lat = 0;
    while (pwm_data_vld !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    cp0 = int'(commit_pending);
    done_k = -1;
    ndone = 0;
    next_k = -1;
    vld_after = -1;
    lim = ((rise + len) > FRAME ? rise + len : FRAME) + 16;
    for (int k = 0; k < lim; k++) begin
      if (k < FRAME) begin
        tr_start[k] = pwm_start;
        tr_vld[k] = pwm_data_vld;
        tr_data[k] = pwm_data;
      end
      if (k == FRAME) vld_after = int'(pwm_data_vld);
      if (frame_done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (k > FRAME && pwm_data_vld === 1'b1) begin
        next_k = k;
        break;
      end
      pwm_busy = (k >= rise && k < rise + len);
      cfg_we = (k == wk) && wwe;
      commit = (k == wk) && wc;
      cfg_addr = wa;
      cfg_wdata = wd;
      if (k == wk) begin
        if (wwe) m_shadow[wa] = wd;
        if (wc) m_pend = 1'b1;
      end
      if (k == 5 && !keep_en) enable = 1'b0;
      step();
    end
    pwm_busy = 1'b0;
    cfg_we = 1'b0;
    commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pwm_start, pwm_data_vld, frame_done, commit_pending, sched_err} !== 5'b0)
      $display("FAIL reset_flags: got %b exp 00000",
               {pwm_start, pwm_data_vld, frame_done, commit_pending, sched_err});
    else n_pass++;
    n_chk++;
    if (pwm_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", pwm_data);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'h0) $display("FAIL reset_cnt: got %0d exp 0", frame_cnt);
    else n_pass++;
    repeat (3) step();
    rst_n = 1'b1;
    m_reset();
    step();
  endtask

  task automatic test_basic();
    int rise;
    for (int b = 0; b < STAGE; b++) cfg_write(3'(b), 8'(16 * (b + 1)), 1'b0);
    cfg_commit();
    n_chk++;
    if (commit_pending !== 1'b1)
      $display("FAIL basic_pend_set: got %b exp 1", commit_pending);
    else n_pass++;
    enable = 1'b1;
    m_start_frame();
    rise = FRAME + $urandom_range(0, 20);
    run_frame(rise, 200, 1'b1, -1, 1'b0, 3'd0, 8'h00, 1'b0);
    m_cnt++;
    n_chk++;
    if (lat != 1) $display("FAIL basic_latency: got %0d exp 1", lat);
    else n_pass++;
    n_chk++;
    if (cp0 != 0) $display("FAIL basic_pend_clear: got %0d exp 0", cp0);
    else n_pass++;
    for (int b = 0; b < STAGE; b++) begin
      n_chk++;
      if (beat_value(b) !== {1'b0, m_active[b]})
        $display("FAIL basic_beat%0d: got %h exp %h", b, beat_value(b), m_active[b]);
      else n_pass++;
    end
    n_chk++;
    if (vld_after != 0) $display("FAIL basic_vld_end: got %0d exp 0", vld_after);
    else n_pass++;
    n_chk++;
    if (ndone != 1 || done_k != exp_done(rise, 200))
      $display("FAIL basic_done: got k=%0d n=%0d exp k=%0d n=1",
               done_k, ndone, exp_done(rise, 200));
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'(m_cnt))
      $display("FAIL basic_cnt: got %0d exp %0d", frame_cnt, m_cnt);
    else n_pass++;
    n_chk++;
    if (next_k != exp_done(rise, 200) + GAP + 1)
      $display("FAIL basic_gap: got %0d exp %0d", next_k, exp_done(rise, 200) + GAP + 1);
    else n_pass++;
  endtask

  task automatic test_shadow();
    logic [7:0] old3;
    int rise, len;
    old3 = m_active[3];
    m_start_frame();
    rise = FRAME + $urandom_range(0, 10);
    len = $urandom_range(5, 40);
    run_frame(rise, len, 1'b1, 40, 1'b1, 3'd3, 8'hFF, 1'b0);
    m_cnt++;
    n_chk++;
    if (beat_value(3) !== {1'b0, old3})
      $display("FAIL shadow_n_ch3: got %h exp %h", beat_value(3), old3);
    else n_pass++;
    m_start_frame();
    run_frame(FRAME - 6, 30, 1'b1, 10, 1'b0, 3'd0, 8'h00, 1'b1);
    m_cnt++;
    n_chk++;
    if (beat_value(3) !== {1'b0, old3})
      $display("FAIL shadow_n1_ch3: got %h exp %h", beat_value(3), old3);
    else n_pass++;
    n_chk++;
    if (done_k != exp_done(FRAME - 6, 30))
      $display("FAIL shadow_busy_early: got %0d exp %0d", done_k, exp_done(FRAME - 6, 30));
    else n_pass++;
    m_start_frame();
    rise = FRAME + $urandom_range(0, 10);
    len = $urandom_range(5, 40);
    run_frame(rise, len, 1'b0, -1, 1'b0, 3'd0, 8'h00, 1'b0);
    m_cnt++;
    n_chk++;
    if (beat_value(3) !== 9'h0FF)
      $display("FAIL shadow_n2_ch3: got %h exp 0ff", beat_value(3));
    else n_pass++;
    n_chk++;
    if (next_k != -1 || ndone != 1)
      $display("FAIL shadow_en_drop: got next=%0d n=%0d exp next=-1 n=1", next_k, ndone);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'(m_cnt))
      $display("FAIL shadow_cnt: got %0d exp %0d", frame_cnt, m_cnt);
    else n_pass++;
  endtask

  task automatic test_zero();
    for (int b = 0; b < STAGE; b++) cfg_write(3'(b), 8'h00, 1'b0);
    cfg_write(3'd0, 8'h00, 1'b1);
    enable = 1'b1;
    m_start_frame();
    run_frame(0, FRAME + 40, 1'b0, -1, 1'b0, 3'd0, 8'h00, 1'b0);
    m_cnt++;
    n_chk++;
    if (beat_value(0) !== 9'h000 || beat_value(7) !== 9'h000)
      $display("FAIL zero_data: got %h/%h exp 000/000", beat_value(0), beat_value(7));
    else n_pass++;
    n_chk++;
    if (done_k != FRAME || ndone != 1)
      $display("FAIL zero_done: got k=%0d n=%0d exp k=%0d n=1", done_k, ndone, FRAME);
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'(m_cnt))
      $display("FAIL zero_cnt: got %0d exp %0d", frame_cnt, m_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int rise, len, nw, wk;
    for (int it = 0; it < 4; it++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) cfg_write(3'($urandom), 8'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) cfg_write(3'($urandom), 8'($urandom), 1'b1);
      n_chk++;
      if (commit_pending !== m_pend)
        $display("FAIL rand%0d_pend: got %b exp %b", it, commit_pending, m_pend);
      else n_pass++;
      enable = 1'b1;
      m_start_frame();
      rise = FRAME - 3 + $urandom_range(0, 30);
      len = $urandom_range(5, 60);
      wk = $urandom_range(0, 200);
      run_frame(rise, len, 1'b0, wk, 1'($urandom), 3'($urandom), 8'($urandom),
                1'($urandom));
      m_cnt++;
      for (int b = 0; b < STAGE; b++) begin
        n_chk++;
        if (beat_value(b) !== {1'b0, m_active[b]})
          $display("FAIL rand%0d_beat%0d: got %h exp %h", it, b, beat_value(b), m_active[b]);
        else n_pass++;
      end
      n_chk++;
      if (done_k != exp_done(rise, len) || ndone != 1)
        $display("FAIL rand%0d_done: got k=%0d n=%0d exp k=%0d n=1",
                 it, done_k, ndone, exp_done(rise, len));
      else n_pass++;
      n_chk++;
      if (frame_cnt !== 16'(m_cnt))
        $display("FAIL rand%0d_cnt: got %0d exp %0d", it, frame_cnt, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw;
    cfg_write(3'd4, 8'h5A, 1'b1);
    enable = 1'b1;
    m_start_frame();
    n = 0;
    while (pwm_data_vld !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_chk++;
    if (n != 1) $display("FAIL mid_latency: got %0d exp 1", n);
    else n_pass++;
    repeat (4 * BEAT + 7) step();
    n_chk++;
    if (pwm_data !== m_active[4])
      $display("FAIL mid_beat4: got %h exp %h", pwm_data, m_active[4]);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pwm_start, pwm_data_vld, frame_done, commit_pending} !== 4'b0 ||
        pwm_data !== 8'h00 || frame_cnt !== 16'h0)
      $display("FAIL mid_async: got %b %h %0d exp 0000 00 0",
               {pwm_start, pwm_data_vld, frame_done, commit_pending}, pwm_data, frame_cnt);
    else n_pass++;
    enable = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      step();
      if (frame_done !== 1'b0) saw = 1'b1;
    end
    n_chk++;
    if (saw) $display("FAIL mid_no_done: got pulse exp none");
    else n_pass++;
    rst_n = 1'b1;
    m_reset();
    step();
    enable = 1'b1;
    m_start_frame();
    run_frame(FRAME + 5, 20, 1'b0, -1, 1'b0, 3'd0, 8'h00, 1'b0);
    m_cnt++;
    n_chk++;
    if (done_k != exp_done(FRAME + 5, 20) || beat_value(4) !== 9'h000)
      $display("FAIL mid_bank_clear: got k=%0d b4=%h exp k=%0d b4=000",
               done_k, beat_value(4), exp_done(FRAME + 5, 20));
    else n_pass++;
    n_chk++;
    if (frame_cnt !== 16'(m_cnt))
      $display("FAIL mid_cnt_restart: got %0d exp %0d", frame_cnt, m_cnt);
    else n_pass++;
    n_chk++;
    if (sched_err !== 1'b0) $display("FAIL sched_err: got %b exp 0", sched_err);
    else n_pass++;
  endtask

  initial begin
    enable = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 3'd0;
    cfg_wdata = 8'h00;
    commit = 1'b0;
    pwm_busy = 1'b0;
    m_reset();
    test_reset();
    test_basic();
    test_shadow();
    test_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
